// File: rtl/huffman_encoder_if.sv
// Handshake bundle for the serial Huffman encoder: word input side and bit output side.
interface huffman_encoder_if #(
  parameter int unsigned row = 8,
  parameter int unsigned bw  = 4
);
  logic [row*bw-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              bit_out;
  logic              bit_valid;
  logic              bit_ready;
  logic              bit_last;

  modport master (
    output in_data, in_valid, bit_ready,
    input  in_ready, bit_out, bit_valid, bit_last
  );

  modport slave (
    input  in_data, in_valid, bit_ready,
    output in_ready, bit_out, bit_valid, bit_last
  );
endinterface

// File: rtl/huffman_encoder.sv
// Serializing canonical-prefix Huffman encoder for 4-bit activations.
// Emits one code bit per cycle, lane 0 first, MSB first within each code.
module huffman_encoder #(
  parameter int unsigned row    = 8,
  parameter int unsigned bw     = 4,
  parameter int unsigned cnt_bw = 16
) (
  input  logic              clk,
  input  logic              reset,
  huffman_encoder_if.slave  bus,
  output logic [cnt_bw-1:0] bits_sent,
  output logic [cnt_bw-1:0] words_sent
);

  localparam int unsigned WORD_W = row * bw;
  localparam int unsigned LANE_W = (row > 1) ? $clog2(row) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_nxt;
  logic [WORD_W-1:0]  word;
  logic [LANE_W-1:0]  lane;
  logic [2:0]         bitidx;
  logic [3:0]         sym;
  logic [7:0]         code;
  logic [2:0]         len;
  logic               code_end;
  logic               last_bit;
  logic               bit_hs;
  logic               capture;

  always_comb sym = 4'(word >> (32'(lane) * bw));

  // Code value is right-aligned in code; len is the number of valid bits.
  always_comb begin
    code = 8'd0;
    len  = 3'd1;
    if (sym == 4'd0) begin
      code = 8'd0;
      len  = 3'd1;
    end else if (sym <= 4'd5) begin
      code = 8'(sym) + 8'd7;
      len  = 3'd4;
    end else if (sym <= 4'd7) begin
      code = 8'(sym) + 8'd20;
      len  = 3'd5;
    end else begin
      code = 8'(sym) + 8'd48;
      len  = 3'd6;
    end
  end

  assign code_end      = (bitidx == 3'(len - 3'd1));
  assign last_bit      = (state == SHIFT) && (lane == LANE_W'(row - 1)) && code_end;
  assign bus.bit_valid = (state == SHIFT);
  assign bus.bit_out   = (state == SHIFT) && code[3'(len - 3'd1 - bitidx)];
  assign bus.bit_last  = last_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, input acceptance and datapath strobes.
  always_comb begin
    state_nxt    = state;
    bus.in_ready = 1'b0;
    capture      = 1'b0;
    bit_hs       = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          capture   = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        bit_hs = bus.bit_ready;
        if (bus.bit_ready && last_bit) begin
          bus.in_ready = 1'b1;
          if (bus.in_valid) capture   = 1'b1;
          else              state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word   <= '0;
      lane   <= '0;
      bitidx <= '0;
    end else if (capture) begin
      word   <= bus.in_data;
      lane   <= '0;
      bitidx <= '0;
    end else if (bit_hs) begin
      if (code_end) begin
        bitidx <= '0;
        lane   <= lane + LANE_W'(1);
      end else begin
        bitidx <= bitidx + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bits_sent  <= '0;
      words_sent <= '0;
    end else begin
      if (bit_hs)             bits_sent  <= bits_sent + cnt_bw'(1);
      if (bit_hs && last_bit) words_sent <= words_sent + cnt_bw'(1);
    end
  end

endmodule

// File: tb/tb_huffman_encoder.sv
// Scoreboard bench for huffman_encoder: expected bits queued at word acceptance, checked per bit handshake.
module tb_huffman_encoder;

  localparam int unsigned ROW    = 8;
  localparam int unsigned BW     = 4;
  localparam int unsigned CNT_BW = 16;

  logic clk = 1'b0;
  logic reset;
  logic [CNT_BW-1:0] bits_sent;
  logic [CNT_BW-1:0] words_sent;

  always #5 clk = ~clk;

  huffman_encoder_if #(.row(ROW), .bw(BW)) bus ();

  huffman_encoder #(.row(ROW), .bw(BW), .cnt_bw(CNT_BW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .bits_sent  (bits_sent),
    .words_sent (words_sent)
  );

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t  sb[$];
  int    n_tests   = 0;
  int    n_fail    = 0;
  int    exp_bits  = 0;
  int    exp_words = 0;
  int    popped    = 0;
  int    gaps      = 0;
  bit    stall_mode = 1'b0;
  int    ready_phase = 0;

  string codes [16] = '{"0", "1000", "1001", "1010", "1011", "1100", "11010", "11011",
                        "111000", "111001", "111010", "111011",
                        "111100", "111101", "111110", "111111"};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] d);
    logic [3:0] s;
    string      c;
    exp_t       e;
    for (int k = 0; k < int'(ROW); k++) begin
      s = d[4*k +: 4];
      c = codes[s];
      for (int i = 0; i < c.len(); i++) begin
        e.b    = (c[i] == "1");
        e.last = (k == int'(ROW) - 1) && (i == c.len() - 1);
        sb.push_back(e);
        exp_bits++;
      end
    end
    exp_words++;
  endtask

  task automatic send_word(input logic [31:0] d, input bit hold);
    bit ok;
    ok = 1'b0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    if (ok) push_word(d);
    #1;
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.bit_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check({tag, "_drain_timeout"}, 32'd0, 32'd1);
    check({tag, "_bits_sent"},  32'(bits_sent),  32'(exp_bits % 65536));
    check({tag, "_words_sent"}, 32'(words_sent), 32'(exp_words % 65536));
    check({tag, "_in_ready"},   32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Downstream ready: constant 1, or the repeating 1,0,0 stall pattern.
  initial begin
    bus.bit_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_mode) begin
        bus.bit_ready = (ready_phase == 0);
        ready_phase   = (ready_phase + 1) % 3;
      end else begin
        bus.bit_ready = 1'b1;
      end
    end
  end

  // Bit monitor: scoreboard pops, stall stability, in_ready on the last-bit handshake, gap count.
  logic prev_stall = 1'b0;
  logic prev_out   = 1'b0;
  logic prev_last  = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_bit_out",  32'(bus.bit_out),  32'(prev_out));
        check("stall_bit_last", 32'(bus.bit_last), 32'(prev_last));
      end
      if (bus.bit_valid && bus.bit_ready) begin
        if (sb.size() == 0) begin
          check("sb_empty", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("bit_out",  32'(bus.bit_out),  32'(e.b));
          check("bit_last", 32'(bus.bit_last), 32'(e.last));
          popped++;
        end
        if (bus.bit_last) check("in_ready_on_last", 32'(bus.in_ready), 32'd1);
      end
      if (!bus.bit_valid && sb.size() != 0) gaps++;
      prev_stall = bus.bit_valid && !bus.bit_ready;
      prev_out   = bus.bit_out;
      prev_last  = bus.bit_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #12;
    check("rst_in_ready",   32'(bus.in_ready),  32'd1);
    check("rst_bit_valid",  32'(bus.bit_valid), 32'd0);
    check("rst_bit_out",    32'(bus.bit_out),   32'd0);
    check("rst_bit_last",   32'(bus.bit_last),  32'd0);
    check("rst_bits_sent",  32'(bits_sent),     32'd0);
    check("rst_words_sent", 32'(words_sent),    32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    send_word(32'h0000_0000, 1'b0);
    drain("zeros");

    send_word(32'h0000_0761, 1'b0);
    drain("mixed");

    send_word(32'hFFFF_FFFF, 1'b0);
    drain("ones");

    stall_mode  = 1'b1;
    ready_phase = 0;
    send_word(32'h0000_0005, 1'b0);
    drain("stall");
    stall_mode = 1'b0;
    @(posedge clk);
    #1;

    gaps = 0;
    send_word(32'h0000_0000, 1'b1);
    send_word(32'h0000_0001, 1'b0);
    drain("b2b");
    check("b2b_gaps", 32'(gaps), 32'd0);

    p0 = popped;
    send_word(32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (popped >= p0 + 3) break;
    end
    check("mid_bits_seen", 32'(popped - p0), 32'd3);
    reset = 1'b1;
    #1;
    check("mid_rst_bit_valid",  32'(bus.bit_valid), 32'd0);
    check("mid_rst_bit_last",   32'(bus.bit_last),  32'd0);
    check("mid_rst_bits_sent",  32'(bits_sent),     32'd0);
    check("mid_rst_words_sent", 32'(words_sent),    32'd0);
    sb.delete();
    exp_bits  = 0;
    exp_words = 0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    p0 = popped;
    send_word(32'h0000_0000, 1'b0);
    drain("post_rst");
    check("post_rst_bits", 32'(popped - p0), 32'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
